// File: rtl/pwm_fade_ctrl.sv
// Multi-channel PWM with per-channel fade toward a host-written target.
// Duty changes land only on the edge that ends the counter's MAX cycle.
module pwm_fade_ctrl #(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned CTR_LEN  = 8,
  parameter int unsigned RATE_LEN = 16,
  parameter int unsigned CH_W     = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CTR_LEN-1:0]           ctr_value,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [CH_W-1:0]              wr_chan,
  input  logic [CTR_LEN-1:0]           wr_target,
  input  logic [RATE_LEN-1:0]          wr_rate,
  input  logic                         wr_jump,
  output logic [CHANNELS*CTR_LEN-1:0]  duty,
  output logic [CHANNELS-1:0]          busy,
  output logic [CHANNELS-1:0]          pwm
);

  logic [CTR_LEN-1:0]  duty_q     [CHANNELS];
  logic [CTR_LEN-1:0]  duty_d     [CHANNELS];
  logic [CTR_LEN-1:0]  target_q   [CHANNELS];
  logic [CTR_LEN-1:0]  target_d   [CHANNELS];
  logic [RATE_LEN-1:0] rate_q     [CHANNELS];
  logic [RATE_LEN-1:0] rate_d     [CHANNELS];
  logic [RATE_LEN-1:0] rate_cnt_q [CHANNELS];
  logic [RATE_LEN-1:0] rate_cnt_d [CHANNELS];
  logic [CHANNELS-1:0] jump_pend_q, jump_pend_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;

  logic boundary;
  logic wr_fire;

  assign boundary = &ctr_value;
  // Refusing writes in the boundary cycle keeps a write from racing a step.
  assign wr_ready = rst_n & ~boundary;
  assign wr_fire  = wr_valid & wr_ready;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      duty_d[i]      = duty_q[i];
      target_d[i]    = target_q[i];
      rate_d[i]      = rate_q[i];
      rate_cnt_d[i]  = rate_cnt_q[i];
      jump_pend_d[i] = jump_pend_q[i];
      pwm_d[i]       = (ctr_value < duty_q[i]);

      if (boundary) begin
        if (jump_pend_q[i]) begin
          duty_d[i]      = target_q[i];
          jump_pend_d[i] = 1'b0;
          rate_cnt_d[i]  = rate_q[i];
        end else if (duty_q[i] != target_q[i]) begin
          if (rate_cnt_q[i] == '0) begin
            duty_d[i]     = (duty_q[i] < target_q[i]) ? duty_q[i] + CTR_LEN'(1)
                                                      : duty_q[i] - CTR_LEN'(1);
            rate_cnt_d[i] = rate_q[i];
          end else begin
            rate_cnt_d[i] = rate_cnt_q[i] - RATE_LEN'(1);
          end
        end
      end else if (wr_fire && (wr_chan == CH_W'(i))) begin
        // Out-of-range channel indices match no i and are silently dropped.
        target_d[i]    = wr_target;
        rate_d[i]      = wr_rate;
        rate_cnt_d[i]  = '0;
        jump_pend_d[i] = wr_jump;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        duty_q[i]     <= '0;
        target_q[i]   <= '0;
        rate_q[i]     <= '0;
        rate_cnt_q[i] <= '0;
      end
      jump_pend_q <= '0;
      pwm_q       <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        duty_q[i]     <= duty_d[i];
        target_q[i]   <= target_d[i];
        rate_q[i]     <= rate_d[i];
        rate_cnt_q[i] <= rate_cnt_d[i];
      end
      jump_pend_q <= jump_pend_d;
      pwm_q       <= pwm_d;
    end
  end

  always_comb begin
    duty = '0;
    busy = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      duty[i*CTR_LEN +: CTR_LEN] = duty_q[i];
      busy[i] = (duty_q[i] != target_q[i]) | jump_pend_q[i];
    end
  end

  assign pwm = pwm_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl: six channels, 8-bit counter.
module tb_pwm_fade_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ctr_value = 8'd0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [2:0]  wr_chan = 3'd0;
  logic [7:0]  wr_target = 8'd0;
  logic [15:0] wr_rate = 16'd0;
  logic        wr_jump = 1'b0;
  logic [47:0] duty;
  logic [5:0]  busy;
  logic [5:0]  pwm;

  int checks = 0;
  int errors = 0;

  pwm_fade_ctrl #(
    .CHANNELS(6),
    .CTR_LEN (8),
    .RATE_LEN(16),
    .CH_W    (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ctr_value(ctr_value),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_chan  (wr_chan),
    .wr_target(wr_target),
    .wr_rate  (wr_rate),
    .wr_jump  (wr_jump),
    .duty     (duty),
    .busy     (busy),
    .pwm      (pwm)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ctr_value <= ctr_value + 8'd1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] duty_of(input int ch);
    return duty[ch*8 +: 8];
  endfunction

  // Advances at least one cycle, then stops at the negedge where ctr_value == v.
  task automatic wait_ctr(input int v);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((ctr_value != 8'(v)) && (n < 600));
    if (n >= 600) begin
      errors++;
      $display("FAIL wait_ctr timeout got=%0d exp=%0d", ctr_value, v);
    end
  endtask

  task automatic wr(input int ch, input int tgt, input int rate, input bit jump);
    int n;
    wr_chan   = 3'(ch);
    wr_target = 8'(tgt);
    wr_rate   = 16'(rate);
    wr_jump   = jump;
    wr_valid  = 1'b1;
    n = 0;
    while (!wr_ready && n < 4) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Counts high pwm samples over one period, starting at the current negedge.
  task automatic count_high(input int ch, output int n);
    n = 0;
    for (int k = 0; k < 256; k++) begin
      if (k > 0) @(negedge clk);
      n += int'(pwm[ch]);
    end
  endtask

  int fade_exp[10] = '{1, 1, 1, 2, 2, 2, 3, 3, 3, 4};
  int rev_exp[4]   = '{4, 3, 2, 2};
  int n;

  initial begin
    // Reset and idle
    repeat (5) @(negedge clk);
    check("rst_pwm", pwm, 0);
    check("rst_duty", duty, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", wr_ready, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_ctr(128);
      check("idle_pwm", pwm, 0);
      check("idle_busy", busy, 0);
    end

    // Jump
    wait_ctr(10);
    wr(2, 128, 0, 1'b1);
    check("jump_busy_pend", busy[2], 1);
    check("jump_duty_pre", duty_of(2), 0);
    wait_ctr(0);
    check("jump_duty", duty_of(2), 128);
    check("jump_busy_clr", busy[2], 0);
    count_high(2, n);
    check("jump_pwm_high", n, 128);

    // Fade up, rate 2
    wait_ctr(10);
    wr(0, 4, 2, 1'b0);
    for (int k = 0; k < 10; k++) begin
      wait_ctr(0);
      check($sformatf("fade_duty%0d", k), duty_of(0), fade_exp[k]);
      if (k == 8) check("fade_busy_mid", busy[0], 1);
      if (k == 9) check("fade_busy_end", busy[0], 0);
    end

    // Reversal mid-fade
    wait_ctr(10);
    wr(1, 10, 0, 1'b0);
    for (int k = 0; k < 5; k++) wait_ctr(0);
    check("rev_at5", duty_of(1), 5);
    wait_ctr(10);
    wr(1, 2, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      wait_ctr(0);
      check($sformatf("rev_duty%0d", k), duty_of(1), rev_exp[k]);
    end

    // Handshake: write presented in boundary cycle is held one cycle
    wait_ctr(255);
    wr_chan = 3'd3; wr_target = 8'd50; wr_rate = 16'd0; wr_jump = 1'b1; wr_valid = 1'b1;
    check("hs_rdy_bnd", wr_ready, 0);
    @(negedge clk);
    check("hs_rdy_next", wr_ready, 1);
    check("hs_busy_held", busy[3], 0);
    wr_target = 8'd60;
    @(negedge clk);
    check("hs_busy_acc", busy[3], 1);
    wr_target = 8'd70;
    @(negedge clk);
    wr_valid = 1'b0;
    wait_ctr(0);
    check("hs_last_wins", duty_of(3), 70);
    check("hs_busy_done", busy[3], 0);

    // Out-of-range channel
    wait_ctr(20);
    wr(7, 200, 0, 1'b1);
    check("oor_busy", busy, 0);
    wait_ctr(0);
    check("oor_duty", duty, 48'h00_00_46_80_02_04);

    // Extremes
    wait_ctr(20);
    wr(4, 255, 0, 1'b1);
    wait_ctr(0);
    check("max_duty", duty_of(4), 255);
    count_high(4, n);
    check("max_pwm_low", 256 - n, 1);
    count_high(5, n);
    check("zero_pwm_high", n, 0);
    wait_ctr(20);
    wr(4, 0, 0, 1'b0);
    n = 0;
    do begin
      wait_ctr(0);
      n++;
      if (n == 254) check("long_fade_254", duty_of(4), 1);
    end while (busy[4] && n < 300);
    check("long_fade_periods", n, 255);
    check("long_fade_duty", duty_of(4), 0);
    wait_ctr(0);
    check("no_wrap", duty_of(4), 0);

    // Asynchronous reset mid-run with a jump pending
    wait_ctr(20);
    wr(0, 200, 0, 1'b1);
    wait_ctr(50);
    check("pre_rst_pwm2", pwm[2], 1);
    rst_n = 1'b0;
    #1;
    check("mrst_pwm", pwm, 0);
    check("mrst_duty", duty, 0);
    check("mrst_busy", busy, 0);
    check("mrst_ready", wr_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ctr(0);
    wait_ctr(0);
    check("post_rst_duty", duty, 0);
    check("post_rst_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_fade_ctrl.md
# pwm_fade_ctrl

Multi-channel PWM controller for the LED bank. It compares the free-running PWM counter against one duty register per channel. It moves each duty toward a host-written target at a programmable per-channel rate, and applies every duty change only at a PWM period boundary so no output glitches. It sits between the shared `counter` instance and the LED pins, and takes channel writes from the SPI/AVR register decoder through a valid/ready port.

## Interface

Parameters:
- `CHANNELS`, default 8: number of PWM channels.
- `CTR_LEN`, default 8: counter and duty width; period is 2^CTR_LEN cycles.
- `RATE_LEN`, default 16: width of the per-channel fade rate.
- `CH_W`, default 3: channel index width; must be at least clog2(CHANNELS).

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `ctr_value`  in  CTR_LEN: shared free-running PWM counter; increments by 1 per cycle and wraps.
- `wr_valid`  in  1: channel write request.
- `wr_ready`  out  1: write accepted this cycle when high together with `wr_valid`.
- `wr_chan`  in  CH_W: target channel index.
- `wr_target`  in  CTR_LEN: requested final duty.
- `wr_rate`  in  RATE_LEN: extra PWM periods between 1-LSB steps; 0 means one step per period.
- `wr_jump`  in  1: 1 means load the target directly at the next boundary with no fade.
- `duty`  out  CHANNELS*CTR_LEN: current duties, channel i at bits [i*CTR_LEN +: CTR_LEN].
- `busy`  out  CHANNELS: channel i has duty != target or a pending jump.
- `pwm`  out  CHANNELS: PWM outputs to `led`.

## Operation

- **Boundary cycle:** `ctr_value == 2^CTR_LEN-1`. All duty updates happen on the clock edge that ends a boundary cycle, so the new duty is in force from `ctr_value == 0`.
- **Per-channel state:** `duty`, `target`, `rate`, `rate_cnt`, `jump_pend`. All reset to 0.
- **Write handshake:**
  - `wr_ready = rst_n & ~boundary`. Writes are never accepted in a boundary cycle, which prevents write/step collisions.
  - On acceptance: `target <= wr_target`, `rate <= wr_rate`, `rate_cnt <= 0`, `jump_pend <= wr_jump`.
  - `wr_chan >= CHANNELS`: the write is accepted (ready honoured) and discarded; no state changes.
  - Back-to-back writes are allowed, one per cycle. The last write before a boundary wins.
- **Channel update at each boundary edge, in priority order:**
  - **JUMP:** `jump_pend = 1` → `duty <= target`, `jump_pend <= 0`, `rate_cnt <= rate`.
  - **STEP:** `duty != target` and `rate_cnt == 0` → duty moves by exactly 1 toward target, and `rate_cnt <= rate`.
  - **WAIT:** `duty != target` and `rate_cnt != 0` → `rate_cnt <= rate_cnt - 1`.
  - **IDLE:** `duty == target` → no change.
- **Arithmetic:** steps are ±1 unsigned and never overshoot; duty never wraps past 0 or 2^CTR_LEN-1.
- **Retargeting:** a new target written mid-fade takes effect from the current duty. A reversal of direction is legal.
- **PWM output:**
  - `pwm[i] <= (ctr_value < duty[i])`, registered.
  - Duty 0 gives constant low. Duty 2^CTR_LEN-1 gives high for all but 1 cycle per period.
- **`busy[i]`:** `(duty[i] != target[i]) | jump_pend[i]`, decoded combinationally from registers.

## Timing

- **Reset** (`rst_n` low, asynchronous, any cycle including mid-fade): `pwm = 0`, `duty = 0`, `busy = 0`, `wr_ready = 0`, and all internal state is 0. After release, the first update applies at the first boundary.
- **`pwm` latency:** `pwm[i]` in cycle t+1 reflects `ctr_value` and `duty` sampled in cycle t.
- **Write-to-effect:** a write accepted in period P changes `duty` at the end of P's boundary cycle, if a step or jump is due. The first `pwm` effect appears one cycle after `ctr_value == 0`.
- **Fade duration:** a fade of N LSBs with rate R takes N*(R+1) - R periods from the first boundary after the write.
- **`ctr_value` discontinuity:** only the boundary value is sampled for updates. A skipped MAX value means no update that period.

## Test plan

- **Reset and idle:** hold `rst_n` = 0 mid-run → `pwm` = 0, `duty` = 0, `wr_ready` = 0 immediately. Release with no writes → `pwm` stays 0 and `busy` stays 0 over 3 periods.
- **Jump:** write ch2, target = 128, `wr_jump` = 1 → `duty[2]` = 128 starting at the next `ctr_value == 0`. `pwm[2]` is high for exactly 128 cycles per period. `busy[2]` drops at that same edge.
- **Fade up:** write ch0, target = 4, rate = 2, from duty 0 → duty reads 1, 1, 1, 2, 2, 2, 3, 3, 3, 4 on successive periods (10 periods). `busy[0]` clears when duty reaches 4.
- **Reversal:** write ch1, target = 10, rate = 0, from duty 0. After duty reaches 5, write target = 2 → duty goes 4, 3, 2 on the next three boundaries with no overshoot.
- **Handshake edge cases:** assert `wr_valid` in a boundary cycle → `wr_ready` = 0 and the write is held until the next cycle and accepted there. A write to `wr_chan` = 7 with `CHANNELS` = 6 → accepted with no state change. Two consecutive writes to ch3 → only the second target is used.
- **Extremes:** duty 255 gives `pwm` low for exactly 1 cycle per period. Duty 0 gives constant low. A 255→0 fade with rate 0 completes in 255 periods.
